// File: rtl/ct_had_pcfifo_ctrl.sv
// PC FIFO read/write control for the HAD trace path.
//
// Sequences debug-host reads of the PC FIFO through a small IDLE/RD/ACK FSM.
// It also qualifies retire-PC capture writes.
//
// Ports:
//   cpuclk                 core clock (rising edge)
//   cpurst_b               asynchronous active-low reset
//   regs_pcfifo_en         capture enable
//   regs_pcfifo_rd_freeze  block writes while a read sequence is in flight
//   had_core_dbg_mode      core in debug mode (blocks writes)
//   regs_pcfifo_rd_req     read request pulse from the debug host
//   regs_pcfifo_ovf_clr    clear pulse for the overflow flag
//   ctrl_pcfifo_wen        write qualifier to the FIFO (combinational)
//   ctrl_pcfifo_ren        read strobe to the FIFO (state RD)
//   pcfifo_ctrl_rd_ack     read data valid (state ACK)
//   pcfifo_ctrl_busy       read sequence in progress
//   pcfifo_ctrl_rd_ovf     sticky: a read request was dropped
//   pcfifo_ctrl_rd_cnt     saturating count of completed reads
module ct_had_pcfifo_ctrl (
  input  logic       cpuclk,
  input  logic       cpurst_b,
  input  logic       regs_pcfifo_en,
  input  logic       regs_pcfifo_rd_freeze,
  input  logic       had_core_dbg_mode,
  input  logic       regs_pcfifo_rd_req,
  input  logic       regs_pcfifo_ovf_clr,
  output logic       ctrl_pcfifo_wen,
  output logic       ctrl_pcfifo_ren,
  output logic       pcfifo_ctrl_rd_ack,
  output logic       pcfifo_ctrl_busy,
  output logic       pcfifo_ctrl_rd_ovf,
  output logic [4:0] pcfifo_ctrl_rd_cnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StAck  = 2'd2
  } state_e;

  localparam logic [4:0] CntMax = 5'd31;

  state_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic [4:0] cnt_q, cnt_d;
  logic       drop;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    case (state_q)
      StIdle: begin
        if (regs_pcfifo_rd_req) state_d = StRd;
      end
      StRd: begin
        state_d = StAck;
        if (regs_pcfifo_rd_req) begin
          if (pend_q) drop = 1'b1;
          else        pend_d = 1'b1;
        end
      end
      StAck: begin
        if (pend_q) begin
          // Pending request is consumed; a fresh request this cycle has no slot.
          state_d = StRd;
          pend_d  = 1'b0;
          drop    = regs_pcfifo_rd_req;
        end else if (regs_pcfifo_rd_req) begin
          state_d = StRd;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        pend_d  = 1'b0;
      end
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  assign ovf_d = drop | (ovf_q & ~regs_pcfifo_ovf_clr);
  assign cnt_d = ((state_q == StAck) && (cnt_q != CntMax)) ? cnt_q + 5'd1 : cnt_q;

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctrl_pcfifo_ren    = (state_q == StRd);
    pcfifo_ctrl_rd_ack = (state_q == StAck);
    pcfifo_ctrl_busy   = (state_q == StRd) || (state_q == StAck);
  end

  assign ctrl_pcfifo_wen    = regs_pcfifo_en & ~had_core_dbg_mode &
                              ~(regs_pcfifo_rd_freeze & pcfifo_ctrl_busy);
  assign pcfifo_ctrl_rd_ovf = ovf_q;
  assign pcfifo_ctrl_rd_cnt = cnt_q;

endmodule
